// File: rtl/q2_serial_exec.sv
// Bit-serial execution sequencer for the Q2 datapath.
// Shifts accumulator and operand LSB-first through a one-bit ALU function,
// reassembles the result and flag in parallel, and strobes done on completion.
module q2_serial_exec #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic             f_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] a_o,
  output logic             f_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] x_q;
  logic             f_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] a_out_q;
  logic             f_out_q;

  logic             last_bit;
  logic             a0, x0, x1;
  logic             bit_res;
  logic             cout;
  logic [WIDTH-1:0] a_shift;

  assign last_bit = (cnt_q == CntLast);
  assign a0       = a_q[0];
  assign x0       = x_q[0];
  // X is zero-filled anyway; forcing x1 low on the last bit keeps the shift op explicit.
  assign x1       = last_bit ? 1'b0 : x_q[1];

  // One-bit ALU slice: result bit and flag/carry out for the current op.
  always_comb begin
    bit_res = 1'b0;
    cout    = 1'b0;
    unique case (op_q)
      2'b00: begin
        bit_res = x0;
        cout    = f_q & ~bit_res;
      end
      2'b01: begin
        bit_res = ~(a0 | x0);
        cout    = f_q & ~bit_res;
      end
      2'b10: begin
        bit_res = a0 ^ x0 ^ f_q;
        cout    = (a0 & x0) | (f_q & (a0 ^ x0));
      end
      2'b11: begin
        bit_res = x1;
        cout    = f_q;
      end
      default: ;
    endcase
  end

  assign a_shift = {bit_res, a_q[WIDTH-1:1]};

  // Sequencer FSM: operand load on start, one bit per cycle in RUN, result capture on last bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
      a_q     <= '0;
      x_q     <= '0;
      f_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_out_q <= '0;
      f_out_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start_i) begin
            op_q    <= op_i;
            a_q     <= a_i;
            x_q     <= x_i;
            // Zero-detect ops start with F set; add/shift take the incoming flag.
            f_q     <= op_i[1] ? f_i : 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q   <= a_shift;
          x_q   <= {1'b0, x_q[WIDTH-1:1]};
          f_q   <= cout;
          cnt_q <= cnt_q + CntW'(1);
          if (last_bit) begin
            a_out_q <= a_shift;
            f_out_q <= cout;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign a_o    = a_out_q;
  assign f_o    = f_out_q;

endmodule

// File: tb/tb_q2_serial_exec.sv
// Self-checking bench for q2_serial_exec: directed literal cases plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_q2_serial_exec;

  localparam int unsigned W = 12;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a_in;
  logic [W-1:0]  x_in;
  logic          f_in;
  logic          busy;
  logic          done;
  logic [W-1:0]  a_out;
  logic          f_out;

  int checks = 0;
  int failures = 0;

  q2_serial_exec #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .op_i   (op),
    .a_i    (a_in),
    .x_i    (x_in),
    .f_i    (f_in),
    .busy_o (busy),
    .done_o (done),
    .a_o    (a_out),
    .f_o    (f_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Result of an operation from its arithmetic meaning.
  function automatic void calc(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] x,
                               input logic f, output logic [W-1:0] r, output logic rf);
    logic [W:0] sum;
    case (o)
      2'b00: begin r = x; rf = (x == '0); end
      2'b01: begin r = ~(a | x); rf = (r == '0); end
      2'b10: begin sum = {1'b0, a} + {1'b0, x} + {{W{1'b0}}, f}; r = sum[W-1:0]; rf = sum[W]; end
      default: begin r = x >> 1; rf = f; end
    endcase
  endfunction

  // Transaction model: an accepted start yields a result W edges later.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_a = '0;
  logic         m_f = 1'b0;
  logic [W-1:0] p_a = '0;
  logic         p_f = 1'b0;
  int           rem = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0; m_done = 1'b0; m_a = '0; m_f = 1'b0; rem = 0;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_a = p_a; m_f = p_f; m_done = 1'b1; m_busy = 1'b0;
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          calc(op, a_in, x_in, f_in, p_a, p_f);
          rem = W;
          m_busy = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  logic chk_en = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_a_out", 32'(a_out), 32'(m_a));
        chk("cyc_f_out", 32'(f_out), 32'(m_f));
      end
    end
  end

  // Launch one op at a negedge with busy low; returns at the negedge where done shows.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] x,
                        input logic f, input logic [W-1:0] ea, input logic ef, input string nm);
    int  lat;
    int  bcnt;
    bit  got;
    op = o; a_in = a; x_in = x; f_in = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0; got = 0;
    while (!got && lat < 40) begin
      if (busy) bcnt++;
      if (done) got = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'(W));
    chk({nm, "_busy_cycles"}, 32'(bcnt), 32'(W));
    chk({nm, "_a_out"}, 32'(a_out), 32'(ea));
    chk({nm, "_f_out"}, 32'(f_out), 32'(ef));
  endtask

  initial begin
    int t1;
    int t2;
    bit seen;
    start = 1'b0; op = 2'b00; a_in = '0; x_in = '0; f_in = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_a_out", 32'(a_out), 32'd0);
    chk("reset_f_out", 32'(f_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run_op(2'b10, 12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, "add_7ff");
    @(negedge clk);
    run_op(2'b10, 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, "add_wrap");
    @(negedge clk);
    run_op(2'b10, 12'h000, 12'h000, 1'b1, 12'h001, 1'b0, "add_cin");
    @(negedge clk);
    run_op(2'b01, 12'h0F0, 12'h00F, 1'b0, 12'hF00, 1'b0, "nor_nz");
    @(negedge clk);
    run_op(2'b01, 12'hFFF, 12'h000, 1'b1, 12'h000, 1'b1, "nor_zero");
    @(negedge clk);
    run_op(2'b00, 12'h123, 12'hA5A, 1'b0, 12'hA5A, 1'b0, "load_nz");
    @(negedge clk);
    run_op(2'b00, 12'h456, 12'h000, 1'b0, 12'h000, 1'b1, "load_zero");
    @(negedge clk);
    run_op(2'b11, 12'h000, 12'h803, 1'b1, 12'h401, 1'b1, "shr_803");
    @(negedge clk);
    run_op(2'b11, 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b0, "shr_001");
    // Back-to-back: start presented in the DONE cycle is accepted immediately.
    run_op(2'b00, 12'h000, 12'h3C3, 1'b0, 12'h3C3, 1'b0, "b2b");
    @(negedge clk);

    // Start pulse mid-RUN must be ignored.
    op = 2'b10; a_in = 12'h100; x_in = 12'h023; f_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'b00; x_in = 12'hBAD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    chk("ignore_done_seen", 32'(seen), 32'd1);
    chk("ignore_a_out", 32'(a_out), 32'h123);
    @(negedge clk);
    chk("ignore_no_relaunch", 32'(busy), 32'd0);

    // Start held high: two done pulses 13 cycles apart.
    op = 2'b00; x_in = 12'h0F0; start = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      @(negedge clk);
      if (done) begin
        if (t1 < 0) begin
          t1 = i;
          x_in = 12'h00F;
        end else t2 = i;
      end
    end
    start = 1'b0;
    chk("held_done_gap", 32'(t2 - t1), 32'd13);
    chk("held_second_a", 32'(a_out), 32'h00F);
    @(negedge clk);
    @(negedge clk);

    // Reset five cycles into an add aborts it with no done.
    op = 2'b10; a_in = 12'h555; x_in = 12'h0AA; f_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_a_out", 32'(a_out), 32'd0);
    chk("abort_f_out", 32'(f_out), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      if (i == 2) rst_n = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op(2'b10, 12'h555, 12'h0AA, 1'b1, 12'h600, 1'b0, "post_reset");
    @(negedge clk);

    // Random traffic, including starts while busy.
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      a_in  = W'($urandom);
      x_in  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      f_in  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/q2_serial_exec.md
# q2_serial_exec

Bit-serial execution sequencer for the Q2 datapath. It loads a WIDTH-bit accumulator and operand in parallel and shifts both LSB-first through the per-bit ALU function, one bit per clock. It reassembles the serial result bits and the flag into parallel form and reports completion with a one-cycle strobe. It sits between the instruction control unit, which issues start/op, and the one-bit ALU slice, driving that slice's a0/x0/x1/f/op inputs and consuming its out/cout.

## Interface
- WIDTH, 12, datapath width in bits (≥2); bit counter is $clog2(WIDTH) bits.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  2  {op4,op3}: 00 load, 01 nor, 10 add, 11 shift-right.
- a_in  in  WIDTH  accumulator operand.
- x_in  in  WIDTH  second operand.
- f_in  in  1  flag in (carry-in for add, preserved for shift).
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle completion strobe.
- a_out  out  WIDTH  result; updated only on completion.
- f_out  out  1  flag result; updated only on completion.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE with busy=0, done=0, a_out=0, f_out=0, shift registers and counter cleared.
- IDLE/DONE with start=1: latch op, load A←a_in, X←x_in, counter←0, go to RUN. Flag init: F←1 for op 00/01; F←f_in for op 10/11.
- DONE with start=0 → IDLE. start while busy=1 is ignored (no queuing).
- RUN, each cycle: a0=A[0], x0=X[0], x1=X[1] (0 when counter=WIDTH-1), f=F. Compute bit and cout as below. Then A←{bit, A[WIDTH-1:1]}, X←{0, X[WIDTH-1:1]}, F←cout, counter+1.
- Per-bit function:
  - op 00: bit=x0, cout=f&~bit.
  - op 01: bit=~(a0|x0), cout=f&~bit.
  - op 10: bit=a0^x0^f, cout=(a0&x0)|(f&(a0^x0)).
  - op 11: bit=x1, cout=f.
- Consequences: ops 00/01 leave F=1 iff the result is all zero. Op 10 leaves F=carry-out of bit WIDTH-1. Op 11 leaves F=f_in, and the result is X logically shifted right by 1.
- Completion: when counter=WIDTH-1 in RUN, on that edge a_out←final A (including this bit), f_out←final cout, state→DONE.
- Arithmetic is modulo 2^WIDTH; no other status.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values, and no done is issued for the aborted operation.

## Timing
- start sampled high at edge N (busy=0) → busy=1 after edge N through edge N+WIDTH; RUN covers edges N+1..N+WIDTH.
- done=1 and a_out/f_out valid for the cycle after edge N+WIDTH; busy=0 in that cycle.
- Back-to-back: start high during the DONE cycle is accepted at edge N+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- a_out/f_out hold their values until the next completion or reset; they do not change during RUN.
- done never asserts in consecutive cycles.

## Test plan (WIDTH=12)
- Add with carries:
  - a_in=0x7FF, x_in=0x001, f_in=0 → a_out=0x800, f_out=0. done is exactly 12 cycles after the start edge; busy is high for 12 cycles.
  - a_in=0xFFF, x_in=0x001, f_in=0 → 0x000, f_out=1.
  - a_in=0, x_in=0, f_in=1 → 0x001, f_out=0.
- Nor/zero flag:
  - a_in=0x0F0, x_in=0x00F → a_out=0xF00, f_out=0.
  - a_in=0xFFF, x_in=0x000 → a_out=0x000, f_out=1.
- Load:
  - x_in=0xA5A, f_in=0 → a_out=0xA5A, f_out=0.
  - x_in=0x000 → a_out=0x000, f_out=1.
- Shift:
  - x_in=0x803, f_in=1 → a_out=0x401, f_out=1.
  - x_in=0x001, f_in=0 → a_out=0x000, f_out=0.
- Handshake:
  - A start pulse mid-RUN is ignored; the result matches the first operation.
  - A start held through DONE launches a second operation at the next edge, and two done pulses occur 13 cycles apart.
- Reset: drop rst_n 5 cycles into an add.
  - Outputs go to 0 asynchronously, with no done.
  - A new start after release completes normally.
